// File: rtl/wav_stream_writer.sv
// rtl/wav_stream_writer.sv - mono 16-bit PCM .wav byte stream generator
// Emits a 44-byte RIFF header, then buffered samples low byte first, over a valid/ready byte sink.
module wav_stream_writer #(
   parameter int SAMPLE_RATE = 48000,
   parameter int NUM_SAMPLES = 48000,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        I_DV,
   input  logic [15:0] DI,
   output logic        O_BV,
   output logic [7:0]  O_BYTE,
   input  logic        I_RDY,
   output logic        O_OVF,
   output logic        O_DONE
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [31:0] NUM_W = 32'(NUM_SAMPLES);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   function automatic logic [31:0] le32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [15:0] le16(input logic [15:0] v);
      return {v[7:0], v[15:8]};
   endfunction

   // Byte 0 of the header sits in the most significant byte
   localparam logic [351:0] HDR = {
      "RIFF", le32(32'(36 + 2 * NUM_SAMPLES)), "WAVE", "fmt ", le32(32'd16),
      le16(16'd1), le16(16'd1), le32(32'(SAMPLE_RATE)), le32(32'(2 * SAMPLE_RATE)),
      le16(16'd2), le16(16'd16), "data", le32(32'(2 * NUM_SAMPLES))
   };

   typedef enum logic [1:0] {S_HEADER, S_DATA_LO, S_DATA_HI, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [5:0]    idx_q, idx_d;
   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [15:0]   mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d, count_mid;
   logic [31:0]   emitted_q, emitted_d, accepted_q, accepted_d;
   logic          bv_q, bv_d, ovf_q, ovf_d, done_q, done_d;
   logic [7:0]    byte_q, byte_d;
   logic          xfer, pop, full, wr_req, wr_en;
   logic [15:0]   head;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      emitted_d  = emitted_q;
      accepted_d = accepted_q;
      ovf_d      = ovf_q;
      pop        = 1'b0;
      xfer       = bv_q & I_RDY;
      full       = (count_q == FULL_CNT);
      wr_req     = I_DV && (state_q != S_DONE) && (accepted_q != NUM_W);
      wr_en      = wr_req && !full;
      if (wr_req && full) ovf_d = 1'b1;

      case (state_q)
         S_HEADER: begin
            if (xfer) begin
               if (idx_q == 6'd43) state_d = S_DATA_LO;
               else                idx_d   = idx_q + 6'd1;
            end
         end
         S_DATA_LO: begin
            if (xfer) state_d = S_DATA_HI;
         end
         S_DATA_HI: begin
            if (xfer) begin
               pop       = 1'b1;
               emitted_d = emitted_q + 32'd1;
               state_d   = (emitted_d == NUM_W) ? S_DONE : S_DATA_LO;
            end
         end
         default: ;
      endcase

      if (wr_en) begin
         mem_d[wr_ptr_q] = DI;
         wr_ptr_d        = wr_ptr_q + AW'(1);
         accepted_d      = accepted_q + 32'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_mid = count_q - {{AW{1'b0}}, pop};
      count_d   = count_mid + {{AW{1'b0}}, wr_en};

      // An empty FIFO forwards the incoming sample straight to the output register
      head = (count_mid == '0) ? DI : mem_q[rd_ptr_d];

      case (state_d)
         S_HEADER: begin
            bv_d   = 1'b1;
            byte_d = HDR[{6'd43 - idx_d, 3'b000} +: 8];
         end
         S_DATA_LO: begin
            bv_d   = (count_d != '0);
            byte_d = bv_d ? head[7:0] : 8'h00;
         end
         S_DATA_HI: begin
            bv_d   = 1'b1;
            byte_d = head[15:8];
         end
         default: begin
            bv_d   = 1'b0;
            byte_d = 8'h00;
         end
      endcase
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= S_HEADER;
         idx_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         emitted_q  <= '0;
         accepted_q <= '0;
         bv_q       <= 1'b0;
         byte_q     <= 8'h00;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         emitted_q  <= emitted_d;
         accepted_q <= accepted_d;
         bv_q       <= bv_d;
         byte_q     <= byte_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
      end
   end

   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   assign O_BV   = bv_q;
   assign O_BYTE = byte_q;
   assign O_OVF  = ovf_q;
   assign O_DONE = done_q;

endmodule
